// File: rtl/karatsuba_seq_mult_if.sv
// Operand/product handshake bundle for karatsuba_seq_mult.
// The master drives operands and accepts products; the slave is the multiplier.
interface karatsuba_seq_mult_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] z;
  logic           busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/karatsuba_seq_mult.sv
// Multi-cycle unsigned N x N -> 2N multiplier around one shared (H+1)-bit array multiplier.
// Define KARATSUBA_3MULT_EN for the 3-product Karatsuba schedule (3-cycle latency instead of 4).
module karatsuba_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o
);
  always_comb begin
    logic c;
    s_o = '0;
    c   = c_i;
    for (int unsigned i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
  end
endmodule

module karatsuba_half_mult #(
  parameter int W = 9
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  logic [2*W-1:0] row [W+1];

  assign row[0] = '0;

  for (genvar i = 0; i < W; i++) begin : g_row
    logic [2*W-1:0] pp;
    assign pp = b_i[i] ? ({{W{1'b0}}, a_i} << i) : '0;
    karatsuba_rca #(.W(2*W)) u_add (
      .a_i (row[i]),
      .b_i (pp),
      .c_i (1'b0),
      .s_o (row[i+1])
    );
  end

  assign p_o = row[W];
endmodule

module karatsuba_seq_mult #(
  parameter int N = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  karatsuba_seq_mult_if.slave bus
);
  localparam int H  = N / 2;
  localparam int PW = 2 * H + 2;
  localparam int AW = 2 * N;

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("karatsuba_seq_mult: N must be even and >= 4");
  end

`ifdef KARATSUBA_3MULT_EN
  localparam logic [1:0] LAST_STEP = 2'd2;
`else
  localparam logic [1:0] LAST_STEP = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [N-1:0]  x_q, x_d, y_q, y_d;
  logic [AW-1:0] acc_q, acc_d;

  logic [H-1:0]  xl, xh, yl, yh;
  logic [H:0]    mul_a, mul_b;
  logic [PW-1:0] prod;
  logic [AW-1:0] addend, acc_sum;

  assign xl = x_q[H-1:0];
  assign xh = x_q[N-1:H];
  assign yl = y_q[H-1:0];
  assign yh = y_q[N-1:H];

  karatsuba_half_mult #(.W(H+1)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  karatsuba_rca #(.W(AW)) u_acc (
    .a_i (acc_q),
    .b_i (addend),
    .c_i (1'b0),
    .s_o (acc_sum)
  );

`ifdef KARATSUBA_3MULT_EN
  logic [N-1:0]  z0_q, z0_d, z2_q, z2_d;
  logic [H:0]    xs, ys;
  logic [PW-1:0] mid_t, mid;

  karatsuba_rca #(.W(H+1)) u_xs (
    .a_i ({1'b0, xl}), .b_i ({1'b0, xh}), .c_i (1'b0), .s_o (xs)
  );
  karatsuba_rca #(.W(H+1)) u_ys (
    .a_i ({1'b0, yl}), .b_i ({1'b0, yh}), .c_i (1'b0), .s_o (ys)
  );

  // m - z0 - z2 as two two's-complement subtractions; the result is xh*yl + xl*yh, never negative
  karatsuba_rca #(.W(PW)) u_sub0 (
    .a_i (prod), .b_i (~{2'b00, z0_q}), .c_i (1'b1), .s_o (mid_t)
  );
  karatsuba_rca #(.W(PW)) u_sub2 (
    .a_i (mid_t), .b_i (~{2'b00, z2_q}), .c_i (1'b1), .s_o (mid)
  );

  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    addend = '0;
    case (step_q)
      2'd0: begin
        mul_a  = {1'b0, xl};
        mul_b  = {1'b0, yl};
        addend = AW'(prod);
      end
      2'd1: begin
        mul_a  = {1'b0, xh};
        mul_b  = {1'b0, yh};
        addend = AW'(prod) << N;
      end
      default: begin
        mul_a  = xs;
        mul_b  = ys;
        addend = AW'(mid) << H;
      end
    endcase
  end

  always_comb begin
    z0_d = z0_q;
    z2_d = z2_q;
    if (state_q == S_MUL) begin
      if (step_q == 2'd0) z0_d = prod[N-1:0];
      if (step_q == 2'd1) z2_d = prod[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z0_q <= '0;
      z2_q <= '0;
    end else begin
      z0_q <= z0_d;
      z2_q <= z2_d;
    end
  end
`else
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    addend = '0;
    case (step_q)
      2'd0: begin
        mul_a  = {1'b0, xl};
        mul_b  = {1'b0, yl};
        addend = AW'(prod);
      end
      2'd1: begin
        mul_a  = {1'b0, xh};
        mul_b  = {1'b0, yl};
        addend = AW'(prod) << H;
      end
      2'd2: begin
        mul_a  = {1'b0, xl};
        mul_b  = {1'b0, yh};
        addend = AW'(prod) << H;
      end
      default: begin
        mul_a  = {1'b0, xh};
        mul_b  = {1'b0, yh};
        addend = AW'(prod) << N;
      end
    endcase
  end
`endif

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    x_d           = x_q;
    y_d           = y_q;
    acc_d         = acc_q;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          x_d     = bus.x;
          y_d     = bus.y;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        bus.busy = 1'b1;
        acc_d    = acc_sum;
        step_d   = step_q + 2'd1;
        if (step_q == LAST_STEP) begin
          step_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.z = acc_q;
endmodule
